// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue and writeback scheduler for the single-precision FPU.
// Accepts one op per cycle, strobes the target unit and books the single
// writeback port in a shifting reservation table so results never collide.
module fpu_issue_ctrl #(
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 8,
    parameter int MAXLAT  = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [4:0] req_rd,
    output logic       sgn_start,
    output logic [1:0] sgn_mode,
    output logic       add_start,
    output logic       add_sub,
    output logic       mul_start,
    output logic       div_start,
    output logic       illegal,
    output logic       wb_valid,
    output logic [1:0] wb_unit,
    output logic [4:0] wb_rd,
    output logic       busy
);

    // Width able to hold any latency 0..MAXLAT, and width of a table index.
    localparam int CW = $clog2(MAXLAT + 1);
    localparam int IW = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    localparam logic [1:0] UNIT_SGN = 2'd0;
    localparam logic [1:0] UNIT_ADD = 2'd1;
    localparam logic [1:0] UNIT_MUL = 2'd2;
    localparam logic [1:0] UNIT_DIV = 2'd3;

    // Latencies outside 1..MAXLAT would index past the reservation table.
    generate
        if (LAT_ADD < 1 || LAT_ADD > MAXLAT ||
            LAT_MUL < 1 || LAT_MUL > MAXLAT ||
            LAT_DIV < 1 || LAT_DIV > MAXLAT) begin : g_bad_latency
            $error("fpu_issue_ctrl: latency parameter outside 1..MAXLAT");
        end
    endgenerate

    // Reservation table: slot 0 is the writeback happening this cycle.
    logic [MAXLAT-1:0] slot_vld_r;
    logic [1:0]        slot_unit_r [MAXLAT];
    logic [4:0]        slot_rd_r   [MAXLAT];
    logic [CW-1:0]     div_cnt_r;

    // Decode results.
    logic          legal_s;
    logic          is_div_s;
    logic [1:0]    unit_s;
    logic [CW-1:0] lat_s;
    logic [IW-1:0] wr_idx_s;

    // Issue handshake.
    logic [MAXLAT:0] slot_vld_ext_s;
    logic            slot_hit_s;
    logic            req_ready_s;
    logic            accept_s;

    // Start strobes.
    logic       sgn_start_s;
    logic       add_start_s;
    logic       mul_start_s;
    logic       div_start_s;
    logic       illegal_s;
    logic [1:0] sgn_mode_s;
    logic       add_sub_s;

    // Decode the opcode into target unit, latency and legality.
    always_comb begin
        legal_s  = 1'b0;
        is_div_s = 1'b0;
        unit_s   = UNIT_SGN;
        lat_s    = CW'(1);
        case (req_op)
            4'd0, 4'd1, 4'd2: begin
                legal_s = 1'b1;
                unit_s  = UNIT_SGN;
                lat_s   = CW'(1);
            end
            4'd3, 4'd4: begin
                legal_s = 1'b1;
                unit_s  = UNIT_ADD;
                lat_s   = CW'(LAT_ADD);
            end
            4'd5: begin
                legal_s = 1'b1;
                unit_s  = UNIT_MUL;
                lat_s   = CW'(LAT_MUL);
            end
            4'd6: begin
                legal_s  = 1'b1;
                is_div_s = 1'b1;
                unit_s   = UNIT_DIV;
                lat_s    = CW'(LAT_DIV);
            end
            default: begin
                legal_s  = 1'b0;
                is_div_s = 1'b0;
                unit_s   = UNIT_SGN;
                lat_s    = CW'(1);
            end
        endcase
    end

    assign wr_idx_s = IW'(lat_s - CW'(1));

    // Slot L is the one that shifts into slot L-1 this edge; slot MAXLAT is always empty.
    assign slot_vld_ext_s = {1'b0, slot_vld_r};
    assign slot_hit_s     = slot_vld_ext_s[lat_s];

    // Readiness depends on the op and the table state only, never on req_valid.
    always_comb begin
        if (!rstn) begin
            req_ready_s = 1'b0;
        end else if (!legal_s) begin
            req_ready_s = 1'b1;
        end else if (is_div_s && (div_cnt_r != CW'(0))) begin
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = !slot_hit_s;
        end
    end

    assign accept_s = req_valid && req_ready_s;

    // Accept-cycle start strobes; an illegal op only raises the illegal pulse.
    always_comb begin
        sgn_start_s = 1'b0;
        add_start_s = 1'b0;
        mul_start_s = 1'b0;
        div_start_s = 1'b0;
        illegal_s   = 1'b0;
        if (accept_s) begin
            if (legal_s) begin
                case (unit_s)
                    UNIT_SGN: sgn_start_s = 1'b1;
                    UNIT_ADD: add_start_s = 1'b1;
                    UNIT_MUL: mul_start_s = 1'b1;
                    UNIT_DIV: div_start_s = 1'b1;
                    default:  sgn_start_s = 1'b0;
                endcase
            end else begin
                illegal_s = 1'b1;
            end
        end else begin
            illegal_s = 1'b0;
        end
    end

    // Unit configuration follows the presented op; forced quiet during reset.
    always_comb begin
        sgn_mode_s = 2'd0;
        add_sub_s  = 1'b0;
        if (rstn && legal_s && (unit_s == UNIT_SGN)) begin
            sgn_mode_s = req_op[1:0];
        end else begin
            sgn_mode_s = 2'd0;
        end
        if (rstn && (req_op == 4'd4)) begin
            add_sub_s = 1'b1;
        end else begin
            add_sub_s = 1'b0;
        end
    end

    // Shift the reservation table and book the writeback slot of an accepted op.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_vld_r <= '0;
            for (int k = 0; k < MAXLAT; k++) begin
                slot_unit_r[k] <= 2'd0;
                slot_rd_r[k]   <= 5'd0;
            end
        end else begin
            for (int k = 0; k < MAXLAT - 1; k++) begin
                slot_vld_r[k]  <= slot_vld_r[k+1];
                slot_unit_r[k] <= slot_unit_r[k+1];
                slot_rd_r[k]   <= slot_rd_r[k+1];
            end
            slot_vld_r[MAXLAT-1]  <= 1'b0;
            slot_unit_r[MAXLAT-1] <= 2'd0;
            slot_rd_r[MAXLAT-1]   <= 5'd0;
            if (accept_s && legal_s) begin
                slot_vld_r[wr_idx_s]  <= 1'b1;
                slot_unit_r[wr_idx_s] <= unit_s;
                slot_rd_r[wr_idx_s]   <= req_rd;
            end
        end
    end

    // Divider occupancy: counts cycles a new FDIV must still wait. Loaded with
    // LAT_DIV-1 so the next FDIV is ready exactly LAT_DIV cycles after the first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_r <= CW'(0);
        end else if (accept_s && is_div_s) begin
            div_cnt_r <= CW'(LAT_DIV - 1);
        end else if (div_cnt_r != CW'(0)) begin
            div_cnt_r <= div_cnt_r - CW'(1);
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    assign req_ready = req_ready_s;
    assign sgn_start = sgn_start_s;
    assign sgn_mode  = sgn_mode_s;
    assign add_start = add_start_s;
    assign add_sub   = add_sub_s;
    assign mul_start = mul_start_s;
    assign div_start = div_start_s;
    assign illegal   = illegal_s;
    assign wb_valid  = slot_vld_r[0];
    assign wb_unit   = slot_unit_r[0];
    assign wb_rd     = slot_rd_r[0];
    assign busy      = (|slot_vld_r) || (div_cnt_r != CW'(0));

endmodule
